// File: rtl/flash_read_responder.sv
// rtl/flash_read_responder.sv - responder for single-word reads from an asynchronous parallel flash/ROM
//
// Purpose: accepts single-cycle read requests, runs a fixed-wait-state read on
// the external flash, and returns the word with a one-cycle valid pulse. One
// extra request can be queued while a read is in flight; any further request
// is dropped and flagged.
//
// Ports:
//   clk, n_rst         clock, asynchronous active-low reset
//   flash_ready        read request strobe (one request per high cycle)
//   flash_address      word address, valid with flash_ready
//   flashData_out      last word read, held until the next read completes
//   flash_valid        one-cycle pulse when flashData_out is refreshed
//   flash_busy         a read is in progress or a request is queued
//   overrun            one-cycle pulse when a request is dropped
//   ext_ce_n, ext_oe_n external chip/output enables (active-low, registered)
//   ext_addr           external address (registered, stable through a read)
//   ext_data           external read data
module flash_read_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flash_ready,
  input  logic [ADDR_W-1:0] flash_address,
  output logic [DATA_W-1:0] flashData_out,
  output logic              flash_valid,
  output logic              flash_busy,
  output logic              overrun,
  output logic              ext_ce_n,
  output logic              ext_oe_n,
  output logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] WCNT_INIT = 8'(WAIT_STATES);

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        wcnt_q;
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_q;

  logic launch;
  logic latch;
  logic req_while_busy;

  // A launch takes the queued request first; a new request arriving on the
  // same edge simply refills the slot, so nothing is lost in that case.
  assign launch         = (state_q == S_IDLE) && (pend_valid_q || flash_ready);
  assign latch          = (state_q == S_WAIT) && (wcnt_q == 8'd1);
  assign req_while_busy = (state_q != S_IDLE) && flash_ready;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch) state_d = S_SETUP;
      S_SETUP: state_d = S_WAIT;
      S_WAIT:  if (latch) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wcnt_q        <= 8'd0;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
      ext_addr      <= '0;
      ext_ce_n      <= 1'b1;
      ext_oe_n      <= 1'b1;
      flashData_out <= '0;
      flash_valid   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      flash_valid <= 1'b0;
      overrun     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (launch) begin
            ext_ce_n <= 1'b0;
            if (pend_valid_q) begin
              ext_addr <= pend_addr_q;
              if (flash_ready) begin
                pend_addr_q <= flash_address;
              end else begin
                pend_valid_q <= 1'b0;
              end
            end else begin
              ext_addr <= flash_address;
            end
          end
        end
        S_SETUP: begin
          ext_oe_n <= 1'b0;
          wcnt_q   <= WCNT_INIT;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q - 8'd1;
          if (latch) begin
            flashData_out <= ext_data;
            flash_valid   <= 1'b1;
            ext_ce_n      <= 1'b1;
            ext_oe_n      <= 1'b1;
          end
        end
        default: begin
        end
      endcase

      // Requests arriving mid-read (including the latch edge) go to the
      // single pending slot; a full slot keeps its older address.
      if (req_while_busy) begin
        if (pend_valid_q) begin
          overrun <= 1'b1;
        end else begin
          pend_valid_q <= 1'b1;
          pend_addr_q  <= flash_address;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    flash_busy = (state_q != S_IDLE) || pend_valid_q;
  end

endmodule

// File: tb/tb_flash_read_responder.sv
// tb/tb_flash_read_responder.sv - self-checking bench for flash_read_responder
module tb_flash_read_responder;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        flash_ready;
  logic [15:0] flash_address;
  logic [15:0] ext_data;

  logic [15:0] rd_data, ext_addr;
  logic        rd_valid, busy, ovr, ce_n, oe_n;
  logic [15:0] rd1_data, ext_addr1;
  logic        rd1_valid, busy1, ovr1, ce1_n, oe1_n;

  flash_read_responder #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(W)) dut (
    .clk(clk), .n_rst(n_rst), .flash_ready(flash_ready), .flash_address(flash_address),
    .flashData_out(rd_data), .flash_valid(rd_valid), .flash_busy(busy), .overrun(ovr),
    .ext_ce_n(ce_n), .ext_oe_n(oe_n), .ext_addr(ext_addr), .ext_data(ext_data)
  );

  flash_read_responder #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(1)) dut_w1 (
    .clk(clk), .n_rst(n_rst), .flash_ready(flash_ready), .flash_address(flash_address),
    .flashData_out(rd1_data), .flash_valid(rd1_valid), .flash_busy(busy1), .overrun(ovr1),
    .ext_ce_n(ce1_n), .ext_oe_n(oe1_n), .ext_addr(ext_addr1), .ext_data(ext_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Timeline model: a read launched at edge L latches at edge L+1+W; one
  // request may wait behind it, anything more is dropped.
  bit          m_active, m_pend, m_valid, m_over;
  int          m_launch, n;
  logic [15:0] m_addr, m_data, m_pend_addr;

  function automatic void model_reset();
    m_active = 0; m_pend = 0; m_valid = 0; m_over = 0;
    m_addr = 16'h0; m_data = 16'h0; m_pend_addr = 16'h0;
    n++;
  endfunction

  function automatic void model_edge(bit rdy, logic [15:0] a, logic [15:0] d);
    m_valid = 0;
    m_over  = 0;
    if (m_active) begin
      if (rdy) begin
        if (m_pend) m_over = 1;
        else begin m_pend = 1; m_pend_addr = a; end
      end
      if (n == m_launch + 1 + W) begin
        m_data = d; m_valid = 1; m_active = 0;
      end
    end else if (m_pend || rdy) begin
      m_active = 1;
      m_launch = n;
      if (m_pend) begin
        m_addr = m_pend_addr;
        if (rdy) m_pend_addr = a;
        else m_pend = 0;
      end else begin
        m_addr = a;
      end
    end
    n++;
  endfunction

  task automatic compare_all();
    chk("ext_ce_n",  {31'b0, ce_n},     {31'b0, !m_active});
    chk("ext_oe_n",  {31'b0, oe_n},     {31'b0, !(m_active && (n - 1) != m_launch)});
    chk("ext_addr",  {16'b0, ext_addr}, {16'b0, m_addr});
    chk("data_out",  {16'b0, rd_data},  {16'b0, m_data});
    chk("valid",     {31'b0, rd_valid}, {31'b0, m_valid});
    chk("overrun",   {31'b0, ovr},      {31'b0, m_over});
    chk("busy",      {31'b0, busy},     {31'b0, (m_active || m_pend)});
  endtask

  // Drive one edge's inputs at the falling edge, advance the model, and
  // compare at the next falling edge.
  task automatic cycle(input bit rdy, input logic [15:0] a, input logic [15:0] d);
    flash_ready   = rdy;
    flash_address = a;
    ext_data      = d;
    if (n_rst) model_edge(rdy, a, d);
    else model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    n = 0;
    n_rst = 1'b0;
    flash_ready = 1'b0;
    flash_address = 16'h0;
    ext_data = 16'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    chk("reset_ce_n", {31'b0, ce_n}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    n_rst = 1'b1;
    idle(2);

    // Single read 0x0123 with a second request 0x0200 queued at edge 4.
    for (int e = 0; e < 22; e++) begin
      cycle(e == 0 || e == 4, (e == 0) ? 16'h0123 : 16'h0200, (e < 10) ? 16'hBEEF : 16'hCAFE);
      if (e == 0)  chk("single_ext_addr", {16'b0, ext_addr}, 32'h0123);
      if (e == 1)  chk("single_oe_low", {31'b0, oe_n}, 32'd0);
      if (e == 9)  chk("single_data", {16'b0, rd_data}, 32'hBEEF);
      if (e == 9)  chk("single_valid", {31'b0, rd_valid}, 32'd1);
      if (e == 9)  chk("single_ce_high", {31'b0, ce_n}, 32'd1);
      if (e == 10) chk("single_valid_drop", {31'b0, rd_valid}, 32'd0);
      if (e == 10) chk("second_ext_addr", {16'b0, ext_addr}, 32'h0200);
      if (e == 19) chk("second_data", {16'b0, rd_data}, 32'hCAFE);
    end
    idle(3);

    // Overrun: 0x10, 0x20 accepted, 0x30 dropped.
    for (int e = 0; e < 22; e++) begin
      cycle(e == 0 || e == 3 || e == 5, 16'h10 * 16'((e == 0) ? 1 : (e == 3) ? 2 : 3),
            16'($urandom));
      if (e == 5)  chk("overrun_pulse", {31'b0, ovr}, 32'd1);
      if (e == 6)  chk("overrun_drop", {31'b0, ovr}, 32'd0);
      if (e == 10) chk("overrun_second_addr", {16'b0, ext_addr}, 32'h0020);
      if (e == 19) chk("overrun_busy_fall", {31'b0, busy}, 32'd0);
    end
    idle(3);

    // Pending 0x20 and new 0x40 meet at the IDLE launch edge 10.
    for (int e = 0; e < 31; e++) begin
      cycle(e == 0 || e == 3 || e == 10, (e == 0) ? 16'h10 : (e == 3) ? 16'h20 : 16'h40,
            16'($urandom));
      if (e == 10) chk("simul_launch_pend", {16'b0, ext_addr}, 32'h0020);
      if (e == 10) chk("simul_busy", {31'b0, busy}, 32'd1);
      if (e == 20) chk("simul_launch_new", {16'b0, ext_addr}, 32'h0040);
      if (e == 29) chk("simul_valid", {31'b0, rd_valid}, 32'd1);
    end
    idle(3);

    // Reset mid-WAIT.
    for (int e = 0; e < 5; e++) cycle(e == 0, 16'h0ABC, 16'h1234);
    n_rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_ce_n", {31'b0, ce_n}, 32'd1);
    chk("rst_data", {16'b0, rd_data}, 32'h0);
    @(negedge clk);
    cycle(1'b0, 16'h0, 16'h1234);
    n_rst = 1'b1;
    idle(12);

    // New read after release, also the W=1 instance's latency.
    for (int e = 0; e < 12; e++) begin
      cycle(e == 0, 16'h0777, 16'h5A5A);
      if (e == 1) chk("w1_valid_early", {31'b0, rd1_valid}, 32'd0);
      if (e == 2) chk("w1_valid", {31'b0, rd1_valid}, 32'd1);
      if (e == 2) chk("w1_data", {16'b0, rd1_data}, 32'h5A5A);
      if (e == 3) chk("w1_valid_drop", {31'b0, rd1_valid}, 32'd0);
      if (e == 9) chk("post_rst_valid", {31'b0, rd_valid}, 32'd1);
      if (e == 9) chk("post_rst_data", {16'b0, rd_data}, 32'h5A5A);
    end

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 900; i++) begin
      n_rst = ($urandom_range(0, 199) != 0);
      cycle($urandom_range(0, 9) < 3, 16'($urandom), 16'($urandom));
    end
    n_rst = 1'b1;
    idle(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_read_responder.md
# flash_read_responder

Responder end of the network controller's weight/bias flash-read interface. It accepts single-cycle read requests (`flash_ready` with `flash_address`) and runs a parallel read on the external asynchronous flash/ROM with a fixed number of wait states. It returns the 16-bit word on `flashData_out` with a one-cycle `flash_valid` pulse, and holds that word until the next read completes. A one-entry pending slot absorbs a request that arrives while a read is in progress.

## Interface
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data width.
- `WAIT_STATES`, default 8: cycles `ext_oe_n` stays low before data is sampled. Legal range is at least 1; the counter is 8 bits wide.
- `clk`  in  1: clock.
- `n_rst`  in  1: reset, asynchronous, active-low.
- `flash_ready`  in  1: read request, sampled at every rising edge; each high cycle is one request.
- `flash_address`  in  ADDR_W: word address, valid whenever `flash_ready` is high.
- `flashData_out`  out  DATA_W: last word read; held between reads.
- `flash_valid`  out  1: one-cycle pulse in the first cycle a new `flashData_out` is presented.
- `flash_busy`  out  1: high when state is not IDLE or the pending slot is occupied.
- `overrun`  out  1: one-cycle pulse when a request is dropped.
- `ext_ce_n`  out  1: external chip enable, active-low.
- `ext_oe_n`  out  1: external output enable, active-low.
- `ext_addr`  out  ADDR_W: external address, registered.
- `ext_data`  in  DATA_W: external read data.

## Operation
- States: IDLE, SETUP, WAIT.
- **IDLE**
  - A launch occurs when `pend_valid` or `flash_ready` is high. The pending slot has priority.
  - When both are high, `ext_addr <= pend_addr` and the incoming request is written into the pending slot.
  - On launch: `ext_ce_n <= 0`, go to SETUP.
- **SETUP** (one cycle): `ext_oe_n <= 0`, `wcnt <= WAIT_STATES`, go to WAIT.
- **WAIT**
  - Each edge decrements `wcnt`.
  - On the edge where `wcnt == 1`:
    - `flashData_out <= ext_data`
    - `flash_valid <= 1` (registered, one cycle)
    - `ext_ce_n <= 1`, `ext_oe_n <= 1`
    - go to IDLE.
- **Requests while not IDLE** (SETUP or WAIT):
  - Pending slot empty: store `flash_address` into `pend_addr` and set `pend_valid`.
  - Pending slot full: drop the request and pulse `overrun` on the next cycle. The pending slot keeps its older address.
- `pend_valid` clears when the pending request is launched from IDLE.
- `ext_addr` changes only at a launch edge and stays stable through SETUP and WAIT.
- `flashData_out` changes only at the latch edge.
- No arithmetic is done on address or data; both pass through at full width.
- **Reset, including mid-read:**
  - State returns to IDLE and the pending slot is cleared.
  - `flashData_out = 0`, `flash_valid = 0`, `overrun = 0`.
  - `ext_ce_n = 1`, `ext_oe_n = 1`, `ext_addr = 0`, `flash_busy = 0`.
  - The interrupted read produces no `flash_valid`.

## Timing
- Request sampled at edge k (state IDLE):
  - After edge k: SETUP, `ext_ce_n = 0`.
  - After edge k+1: WAIT, `ext_oe_n = 0`.
  - Data is latched at edge k+1+W, where W = WAIT_STATES.
  - `flash_valid` is high during cycle k+1+W…k+2+W.
- Latency is W+1 edges. With the default W = 8, data is stable 9 cycles after the request, inside the 11-cycle window the network controller allows.
- `ext_data` must be stable by edge k+1+W; the external device has W cycles of `oe_n`-to-data time.
- A pending request launches at edge k+2+W (IDLE on the cycle after the latch), so back-to-back reads complete every W+2 cycles.
- `ext_ce_n` is high for at least one cycle between accesses (the IDLE cycle).
- `flash_busy` is combinational from state and `pend_valid`, so it is high in the cycle after a request is sampled.

## Test plan
- **Single read:** W = 8, `flash_ready` pulse at edge 0 with `flash_address = 0x0123`, `ext_data = 0xBEEF`.
  - `ext_addr = 0x0123` after edge 0.
  - `ext_oe_n` low after edge 1.
  - `flashData_out = 0xBEEF` and `flash_valid = 1` for exactly one cycle after edge 9.
  - `ext_ce_n` and `ext_oe_n` high after edge 9.
- **Request during WAIT:** second request 0x0200 at edge 4.
  - First read completes at edge 9.
  - Second launches at edge 10, latches at edge 19.
  - `flash_valid` pulses twice; no `overrun`.
- **Overrun:** requests at edges 0, 3, 5 (addresses 0x10, 0x20, 0x30).
  - `overrun` pulses for one cycle after edge 5.
  - Reads occur for 0x10 and 0x20 only.
  - `flash_busy` falls after the second completion.
- **Simultaneous pending and new request in IDLE:** pending 0x20 plus a new 0x40 at launch edge.
  - 0x20 launches first, 0x40 becomes pending, and both complete in order.
  - No `overrun`.
- **Reset mid-WAIT:** assert `n_rst` at edge 5 of a read.
  - All outputs take reset values immediately (`ext_ce_n = 1`, `flashData_out = 0`).
  - No `flash_valid` after release.
  - A new request after release completes normally.
- **W = 1:** request at edge 0 latches at edge 2; `flash_valid` is high for one cycle after edge 2.
